// File: rtl/alu_mul_seq_if.sv
// Handshake and result bus between the control unit and the sequential multiplier.
interface alu_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, multiplicand, multiplier,
                  input  busy, done, hi, lo);
  modport slave  (input  start, multiplicand, multiplier,
                  output busy, done, hi, lo);
endinterface

// File: rtl/alu_mul_seq.sv
// Radix-2 Booth signed multiplier, one step per clock, WIDTH x WIDTH -> 2*WIDTH.
// hi/lo update only on the final step and hold until the next completion.
module alu_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clock,
  input  logic          clear_n,
  alu_mul_seq_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic             accept, last;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] m;
  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q;
  logic             qm1;
  logic             done_r;
  logic [WIDTH-1:0] hi_r, lo_r;

  logic [WIDTH:0]   m_ext, a_sum, a_sh;
  logic [WIDTH-1:0] q_sh;

  // FSM state register
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        accept   = 1'b1;
        state_nx = RUN;
      end
      RUN: if (cnt == CNT_W'(WIDTH-1)) begin
        last     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Booth add/sub on the WIDTH+1-bit accumulator, then arithmetic shift of {A,Q,q_m1}.
  // The extra A bit keeps M = -2**(WIDTH-1) from overflowing.
  always_comb begin
    m_ext = {m[WIDTH-1], m};
    case ({q[0], qm1})
      2'b01:   a_sum = a + m_ext;
      2'b10:   a_sum = a - m_ext;
      default: a_sum = a;
    endcase
    a_sh = {a_sum[WIDTH], a_sum[WIDTH:1]};
    q_sh = {a_sum[0], q[WIDTH-1:1]};
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      m      <= '0;
      a      <= '0;
      q      <= '0;
      qm1    <= 1'b0;
      cnt    <= '0;
      done_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= last;
      if (accept) begin
        m   <= bus.multiplicand;
        a   <= '0;
        q   <= bus.multiplier;
        qm1 <= 1'b0;
        cnt <= '0;
      end else if (state == RUN) begin
        a   <= a_sh;
        q   <= q_sh;
        qm1 <= q[0];
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          hi_r <= a_sh[WIDTH-1:0];
          lo_r <= q_sh;
        end
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed vector bench for alu_mul_seq: product table plus handshake/reset sequences.
module tb_alu_mul_seq;

  logic clock = 1'b0;
  logic clear_n = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  alu_mul_seq_if #(.WIDTH(32)) bus ();

  alu_mul_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present operands with start for one edge, then scramble them.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.start        = 1'b1;
    tick();
    bus.start        = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
  endtask

  // Called one step after the accepting edge; returns edges counted until done.
  task automatic wait_done(input string name, input logic [63:0] prev, output int lat);
    logic busy_ok, held;
    busy_ok = 1'b1;
    held    = 1'b1;
    lat     = 0;
    while (lat < 100) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if ({bus.hi, bus.lo} !== prev) held = 1'b0;
      tick();
      lat++;
      if (bus.done === 1'b1) break;
    end
    chk({name, "_latency"}, 64'(lat), 64'd32);
    chk({name, "_busy_window"}, {63'd0, busy_ok}, 64'd1);
    chk({name, "_hold"}, {63'd0, held}, 64'd1);
    chk({name, "_busy_at_done"}, {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    int lat, pulses;
    logic [63:0] last_p;

    vecs[0] = '{32'd7,        32'd6,        64'h00000000_0000002A};
    vecs[1] = '{32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1};
    vecs[2] = '{32'hFFFFFFFC, 32'hFFFFFFFC, 64'h00000000_00000010};
    vecs[3] = '{32'h80000000, 32'h80000000, 64'h40000000_00000000};
    vecs[4] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001};
    vecs[5] = '{32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000};
    vecs[6] = '{32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000};
    vecs[7] = '{32'd0,        32'h12345678, 64'h00000000_00000000};
    vecs[8] = '{32'd12345,    32'hFFFFFFFF, 64'hFFFFFFFF_FFFFCFC7};
    vecs[9] = '{32'd1,        32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF};

    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;

    #1 clear_n = 1'b0;
    #1;
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    chk("reset_done", {63'd0, bus.done}, 64'd0);
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    tick();
    tick();
    clear_n = 1'b1;
    tick();

    last_p = 64'd0;
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].a, vecs[i].b);
      wait_done($sformatf("vec%0d", i), last_p, lat);
      chk($sformatf("vec%0d_product", i), {bus.hi, bus.lo}, vecs[i].p);
      tick();
      chk($sformatf("vec%0d_done_pulse", i), {63'd0, bus.done}, 64'd0);
      last_p = vecs[i].p;
    end

    // start and new operands mid-run must be ignored
    issue(32'd100, 32'hFFFFFFF9);
    for (int i = 0; i < 9; i++) tick();
    bus.multiplicand = 32'd5;
    bus.multiplier   = 32'd5;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    while (lat < 100 && bus.done !== 1'b1) begin
      tick();
      lat++;
    end
    chk("ignore_latency", 64'(lat + 10), 64'd32);
    chk("ignore_product", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFD44);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1) pulses++;
    end
    chk("ignore_extra_done", 64'(pulses), 64'd0);
    chk("ignore_idle", {63'd0, bus.busy}, 64'd0);

    // back-to-back: start in the done cycle
    issue(32'hFFFFFFFD, 32'd5);
    wait_done("b2b_first", 64'hFFFFFFFF_FFFFFD44, lat);
    chk("b2b_first_product", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFF1);
    issue(32'd3, 32'd3);
    wait_done("b2b_second", 64'hFFFFFFFF_FFFFFFF1, lat);
    chk("b2b_gap", 64'(lat + 1), 64'd33);
    chk("b2b_second_product", {bus.hi, bus.lo}, 64'd9);

    // asynchronous reset at step 10 aborts the operation
    issue(32'h1234, 32'h10);
    for (int i = 0; i < 9; i++) tick();
    #2 clear_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_done", {63'd0, bus.done}, 64'd0);
    chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    tick();
    clear_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);
    issue(32'hFFFFFFF9, 32'd9);
    wait_done("post_reset", 64'd0, lat);
    chk("post_reset_product", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFC1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
